// File: rtl/hyperram_pkg.sv
// hyperram_pkg: types and bus widths shared by the hyperram core, its bus wrapper and the arbiter
package hyperram_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    localparam int HR_ADDR_W = 32;
    localparam int HR_DATA_W = 32;
    localparam int HR_SEL_W  = 4;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first requester at or above the round-robin pointer, wrapping modulo NUM_PORTS
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IW-1:0]        i_ptr,
    output logic                 o_found,
    output logic [IW-1:0]        o_idx
);
    logic [IW-1:0] w_idx;
    // scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        o_found = |i_req;
        o_idx   = '0;
        w_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_idx = IW'((int'(i_ptr) + i) % NUM_PORTS);
            if (i_req[w_idx]) o_idx = w_idx;
        end
    end
endmodule

// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: round-robin sharing of one hyperram core among NUM_PORTS requesters with a watchdog
module hyperram_arbiter
    import hyperram_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_PORTS-1:0]           req_valid_i,
    input  logic [NUM_PORTS-1:0]           req_wren_i,
    input  logic [NUM_PORTS-1:0]           req_regspace_i,
    input  logic [HR_ADDR_W*NUM_PORTS-1:0] req_addr_i,
    input  logic [HR_DATA_W*NUM_PORTS-1:0] req_data_i,
    input  logic [HR_SEL_W*NUM_PORTS-1:0]  req_sel_i,
    output logic [NUM_PORTS-1:0]           req_ack_o,
    output logic                           req_err_o,
    output logic [HR_DATA_W-1:0]           req_rdata_o,
    output logic                           mem_valid_o,
    output logic                           mem_wren_o,
    output logic                           mem_regspace_o,
    output logic [HR_ADDR_W-1:0]           mem_addr_o,
    output logic [HR_DATA_W-1:0]           mem_data_o,
    output logic [HR_SEL_W-1:0]            mem_sel_o,
    input  logic                           mem_ready_i,
    input  logic [HR_DATA_W-1:0]           mem_rdata_i,
    output logic                           busy_o
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(TIMEOUT + 1);
    arb_state_t           r_state, w_next;
    logic [IW-1:0]        r_ptr, r_grant, w_win;
    logic [CW-1:0]        r_cnt;
    logic                 w_found, w_expire, w_take;
    logic [NUM_PORTS-1:0] w_ack_d;
    logic                 w_wren, w_regspace;
    logic [HR_ADDR_W-1:0] w_addr;
    logic [HR_DATA_W-1:0] w_data;
    logic [HR_SEL_W-1:0]  w_sel;

    rr_picker #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_picker (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    // state register
    always_ff @(posedge clk_i) begin
        r_state <= !rst_ni ? IDLE : w_next;
    end

    // next state: r_cnt counts BUSY cycles from 0, so expiry leaves BUSY TIMEOUT+1 cycles after valid rises
    always_comb begin
        w_expire = r_cnt == CW'(TIMEOUT);
        w_next   = r_state == IDLE ? (w_found ? BUSY : IDLE) :
                   r_state == BUSY ? ((mem_ready_i || w_expire) ? DONE : BUSY) : IDLE;
    end

    // decode: grant strobe, completion vector and the winner's request fields
    always_comb begin
        w_take     = r_state == IDLE && w_found;
        w_ack_d    = w_next == DONE ? NUM_PORTS'(1) << r_grant : '0;
        w_wren     = 1'b0;
        w_regspace = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        w_sel      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_win == IW'(p)) begin
                w_wren     = req_wren_i[p];
                w_regspace = req_regspace_i[p];
                w_addr     = req_addr_i[p*HR_ADDR_W +: HR_ADDR_W];
                w_data     = req_data_i[p*HR_DATA_W +: HR_DATA_W];
                w_sel      = req_sel_i[p*HR_SEL_W +: HR_SEL_W];
            end
        end
    end

    // grant latch, watchdog, completion capture, pointer advance and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ptr          <= '0;
            r_grant        <= '0;
            r_cnt          <= '0;
            req_ack_o      <= '0;
            req_err_o      <= 1'b0;
            req_rdata_o    <= '0;
            mem_valid_o    <= 1'b0;
            mem_wren_o     <= 1'b0;
            mem_regspace_o <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            mem_sel_o      <= '0;
            busy_o         <= 1'b0;
        end else begin
            req_ack_o   <= w_ack_d;
            mem_valid_o <= w_next == BUSY;
            busy_o      <= w_next != IDLE;
            if (w_take) begin
                r_grant        <= w_win;
                r_cnt          <= '0;
                mem_wren_o     <= w_wren;
                mem_regspace_o <= w_regspace;
                mem_addr_o     <= w_addr;
                mem_data_o     <= w_data;
                mem_sel_o      <= w_sel;
            end
            if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
                if (mem_ready_i) begin
                    req_rdata_o <= mem_rdata_i;
                    req_err_o   <= 1'b0;
                end else if (w_expire) begin
                    req_rdata_o <= '0;
                    req_err_o   <= 1'b1;
                end
            end
            if (r_state == DONE) r_ptr <= int'(r_grant) == NUM_PORTS - 1 ? '0 : r_grant + 1'b1;
        end
    end
endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter: directed stimulus with a queued scoreboard checked by a completion monitor
module tb_hyperram_arbiter;
    localparam int NP = 2;
    localparam int TO = 16;

    typedef struct {
        logic [NP-1:0] ack;
        logic          err;
        logic [31:0]   rdata;
        bit            chk_rd;
        int            cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NP-1:0]   req_valid_i = '0;
    logic [NP-1:0]   req_wren_i = '0;
    logic [NP-1:0]   req_regspace_i = '0;
    logic [32*NP-1:0] req_addr_i = '0;
    logic [32*NP-1:0] req_data_i = '0;
    logic [4*NP-1:0] req_sel_i = '0;
    logic [NP-1:0]   req_ack_o;
    logic            req_err_o;
    logic [31:0]     req_rdata_o;
    logic            mem_valid_o, mem_wren_o, mem_regspace_o;
    logic [31:0]     mem_addr_o, mem_data_o;
    logic [3:0]      mem_sel_o;
    logic            mem_ready_i = 1'b0;
    logic [31:0]     mem_rdata_i = '0;
    logic            busy_o;

    exp_t sb[$];
    exp_t m;
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    hyperram_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_wren_i     (req_wren_i),
        .req_regspace_i (req_regspace_i),
        .req_addr_i     (req_addr_i),
        .req_data_i     (req_data_i),
        .req_sel_i      (req_sel_i),
        .req_ack_o      (req_ack_o),
        .req_err_o      (req_err_o),
        .req_rdata_o    (req_rdata_o),
        .mem_valid_o    (mem_valid_o),
        .mem_wren_o     (mem_wren_o),
        .mem_regspace_o (mem_regspace_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_sel_o      (mem_sel_o),
        .mem_ready_i    (mem_ready_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // completion monitor: every ack must match the oldest expected completion
    always @(negedge clk) begin
        if (req_ack_o != '0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected got ack=%b cyc=%0d want no ack", req_ack_o, cyc);
            end else begin
                m = sb.pop_front();
                if (req_ack_o !== m.ack || req_err_o !== m.err || (m.chk_rd && req_rdata_o !== m.rdata) || cyc != m.cyc) begin
                    n_fail++;
                    $display("FAIL ack got ack=%b err=%b rdata=%h cyc=%0d want ack=%b err=%b rdata=%h cyc=%0d",
                             req_ack_o, req_err_o, req_rdata_o, cyc, m.ack, m.err, m.rdata, m.cyc);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s, input logic r);
        req_valid_i[p]         = v;
        req_wren_i[p]          = w;
        req_regspace_i[p]      = r;
        req_addr_i[p*32 +: 32] = a;
        req_data_i[p*32 +: 32] = d;
        req_sel_i[p*4 +: 4]    = s;
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        mem_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_valid_o === 1'b1) begin
                t = cyc;
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_valid got=no mem_valid_o want=mem_valid_o within 40 cycles");
    endtask

    task automatic ready_now(input int p, input logic [31:0] d, input bit chkrd);
        exp_t e;
        mem_ready_i = 1'b1;
        mem_rdata_i = d;
        e.ack    = NP'(1) << p;
        e.err    = 1'b0;
        e.rdata  = d;
        e.chk_rd = chkrd;
        e.cyc    = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 mem_ready_i = 1'b0;
    endtask

    task automatic serve(input int p, input int dly, input logic [31:0] d, input bit chkrd, input logic [31:0] a);
        int t;
        wait_valid(t);
        if (t < 0) return;
        chk("mem_addr", mem_addr_o, a);
        repeat (dly) @(posedge clk);
        #1 ready_now(p, d, chkrd);
    endtask

    initial begin
        int t;
        int c0;
        exp_t e;
        do_reset();
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ack", req_ack_o, 0);
        chk("rst_rdata", req_rdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);

        c0 = cyc;
        set_port(0, 1, 0, 32'h0000_0100, 32'h0, 4'hF, 0);
        wait_valid(t);
        chk("grant_latency", t, c0 + 1);
        chk("read_wren", mem_wren_o, 0);
        repeat (10 - (cyc - t)) @(posedge clk);
        #1 ready_now(0, 32'hDEAD_BEEF, 1);
        req_valid_i = '0;

        do_reset();
        set_port(0, 1, 0, 32'h0000_1000, 32'h0, 4'hF, 0);
        set_port(1, 1, 0, 32'h0000_2000, 32'h0, 4'hF, 0);
        serve(0, 2, 32'hA000_0000, 1, 32'h0000_1000);
        serve(1, 2, 32'hA000_0001, 1, 32'h0000_2000);
        serve(0, 2, 32'hA000_0002, 1, 32'h0000_1000);
        serve(1, 2, 32'hA000_0003, 1, 32'h0000_2000);
        req_valid_i = '0;

        set_port(1, 1, 1, 32'h0000_0300, 32'h1234_5678, 4'b0101, 1);
        wait_valid(t);
        chk("wr_wren", mem_wren_o, 1);
        chk("wr_data", mem_data_o, 32'h1234_5678);
        chk("wr_sel", mem_sel_o, 4'b0101);
        chk("wr_regspace", mem_regspace_o, 1);
        chk("wr_addr", mem_addr_o, 32'h0000_0300);
        set_port(1, 1, 0, 32'hFFFF_FFFC, 32'h0, 4'b1010, 0);
        repeat (3) @(negedge clk);
        chk("wr_hold_wren", mem_wren_o, 1);
        chk("wr_hold_data", mem_data_o, 32'h1234_5678);
        chk("wr_hold_sel", mem_sel_o, 4'b0101);
        chk("wr_hold_regspace", mem_regspace_o, 1);
        chk("wr_hold_addr", mem_addr_o, 32'h0000_0300);
        chk("wr_hold_valid", mem_valid_o, 1);
        @(posedge clk);
        #1 ready_now(1, 32'h5555_AAAA, 0);
        req_valid_i = '0;

        set_port(0, 1, 0, 32'h0000_0400, 32'h0, 4'hF, 0);
        wait_valid(t);
        e.ack    = 2'b01;
        e.err    = 1'b1;
        e.rdata  = 32'h0;
        e.chk_rd = 1'b1;
        e.cyc    = t + TO + 1;
        sb.push_back(e);
        repeat (TO + 1) @(posedge clk);
        #1 req_valid_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("to_valid_low", mem_valid_o, 0);
        @(posedge clk);
        #1 mem_ready_i = 1'b1;
        mem_rdata_i = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 mem_ready_i = 1'b0;
        @(negedge clk);
        chk("late_ready_busy", busy_o, 0);
        chk("late_ready_rdata", req_rdata_o, 0);

        set_port(1, 1, 0, 32'h0000_0500, 32'h0, 4'hF, 0);
        serve(1, TO, 32'hC0FF_EE01, 1, 32'h0000_0500);
        req_valid_i = '0;

        set_port(0, 1, 0, 32'h0000_0600, 32'h0, 4'hF, 0);
        serve(0, 3, 32'h1111_1111, 1, 32'h0000_0600);
        req_valid_i = '0;

        set_port(0, 1, 0, 32'h0000_0700, 32'h0, 4'hF, 0);
        wait_valid(t);
        repeat (5) @(posedge clk);
        #1 rst_ni = 1'b0;
        req_valid_i = '0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
        @(negedge clk);
        chk("midrst_mem_valid", mem_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_ack", req_ack_o, 0);
        chk("midrst_rdata", req_rdata_o, 0);
        chk("midrst_mem_addr", mem_addr_o, 0);
        @(posedge clk);
        #1 mem_ready_i = 1'b1;
        mem_rdata_i = 32'h7777_7777;
        @(posedge clk);
        #1 mem_ready_i = 1'b0;
        @(negedge clk);
        chk("midrst_late_busy", busy_o, 0);
        chk("midrst_late_rdata", req_rdata_o, 0);

        set_port(0, 1, 0, 32'h0000_0800, 32'h0, 4'hF, 0);
        set_port(1, 1, 0, 32'h0000_0900, 32'h0, 4'hF, 0);
        serve(0, 2, 32'h2222_2222, 1, 32'h0000_0800);
        req_valid_i = '0;

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
